rv2t_reg_writeback: RTL and testbench

- Write-back arbiter and scoreboard that drives the write port of the RV2T register file (write_enable / write_addr / write_data_in).
- Merges results from three sources into one registered write per cycle: the single-cycle ALU, the load unit, and the multi-cycle mul/div unit.
- Keeps a busy bit per architectural register for in-flight long-latency ops, and reports read hazards to the decode stage.

---
 rtl/rv2t_reg_writeback.sv | 220 ++++++++++++++++++++++
 tb/tb_rv2t_reg_writeback.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv2t_reg_writeback.sv
// -----------------------------------------------------------------------------
// rv2t_reg_writeback
//
// Write-back arbiter and scoreboard for the RV2T register file write port.
// Three result sources are merged into one registered write per cycle, using
// a fixed priority: ALU, then the deferred-load skid entry, then a fresh load,
// then mul/div. An accepted load that loses arbitration goes into a one-entry
// skid register, so loads are never dropped. A per-register busy bit tracks
// in-flight long-latency ops, and read hazards are reported to decode.
//
// Ports:
//   clk, reset_n (async, active-low), sync_reset (synchronous clear)
//   issue_valid/issue_rd/issue_ready   : long-latency issue; WAW stall when busy
//   rs1_addr/rs2_addr -> rs1_busy/rs2_busy : decode hazard query (x0 never busy)
//   alu_valid/alu_rd/alu_data          : ALU result, no back-pressure
//   ld_valid/ld_ready/ld_rd/ld_data    : load result handshake
//   md_valid/md_ready/md_rd/md_data    : mul/div result handshake
//   write_enable/write_addr/write_data_in : registered register-file write
//   busy_vector                        : registered scoreboard
//
// Optional feature, macro RV2T_WB_STATS_EN:
//   adds wb_conflict_cnt, a 16-bit saturating count of cycles in which two or
//   more sources were competing for the write port.
// -----------------------------------------------------------------------------
module rv2t_reg_writeback #(
    parameter int XLEN          = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sync_reset,
    input  logic                        issue_valid,
    input  logic [REG_ADDR_BITS-1:0]    issue_rd,
    output logic                        issue_ready,
    input  logic [REG_ADDR_BITS-1:0]    rs1_addr,
    input  logic [REG_ADDR_BITS-1:0]    rs2_addr,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    input  logic                        alu_valid,
    input  logic [REG_ADDR_BITS-1:0]    alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [REG_ADDR_BITS-1:0]    ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    input  logic                        md_valid,
    output logic                        md_ready,
    input  logic [REG_ADDR_BITS-1:0]    md_rd,
    input  logic [XLEN-1:0]             md_data,
`ifdef RV2T_WB_STATS_EN
    output logic [15:0]                 wb_conflict_cnt,
`endif
    output logic                        write_enable,
    output logic [REG_ADDR_BITS-1:0]    write_addr,
    output logic [XLEN-1:0]             write_data_in,
    output logic [(2**REG_ADDR_BITS)-1:0] busy_vector
);

    localparam int NREG = 2**REG_ADDR_BITS;

    // Registered state
    logic                       we_q,        we_d;
    logic [REG_ADDR_BITS-1:0]   waddr_q,     waddr_d;
    logic [XLEN-1:0]            wdata_q,     wdata_d;
    logic [NREG-1:0]            busy_q,      busy_d;
    logic                       hold_valid_q, hold_valid_d;
    logic [REG_ADDR_BITS-1:0]   hold_rd_q,   hold_rd_d;
    logic [XLEN-1:0]            hold_data_q, hold_data_d;

    // Arbitration results
    logic                       ld_xfer;
    logic                       win_valid;
    logic                       win_clears;   // winner is a load or mul/div
    logic [REG_ADDR_BITS-1:0]   win_rd;
    logic [XLEN-1:0]            win_data;
    logic                       issue_fire;
    logic [NREG-1:0]            set_vec;
    logic [NREG-1:0]            clr_vec;

    // ------------------------------------------------------------------
    // Handshake / hazard outputs (combinational)
    // ------------------------------------------------------------------
    assign ld_ready    = !hold_valid_q;
    assign ld_xfer     = ld_valid && !hold_valid_q;
    assign issue_ready = !busy_q[issue_rd] || (issue_rd == '0);
    assign issue_fire  = issue_valid && issue_ready;
    assign rs1_busy    = busy_q[rs1_addr] && (rs1_addr != '0);
    assign rs2_busy    = busy_q[rs2_addr] && (rs2_addr != '0);

    // ------------------------------------------------------------------
    // Fixed-priority arbitration and skid-register control
    // ------------------------------------------------------------------
    always_comb begin
        win_valid    = 1'b0;
        win_clears   = 1'b0;
        win_rd       = '0;
        win_data     = '0;
        md_ready     = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;

        if (alu_valid) begin
            win_valid = 1'b1;
            win_rd    = alu_rd;
            win_data  = alu_data;
            // A load accepted this cycle loses to the ALU: park it.
            if (ld_xfer) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = ld_rd;
                hold_data_d  = ld_data;
            end
        end else if (hold_valid_q) begin
            win_valid    = 1'b1;
            win_clears   = 1'b1;
            win_rd       = hold_rd_q;
            win_data     = hold_data_q;
            hold_valid_d = 1'b0;
        end else if (ld_xfer) begin
            win_valid  = 1'b1;
            win_clears = 1'b1;
            win_rd     = ld_rd;
            win_data   = ld_data;
        end else if (md_valid) begin
            win_valid  = 1'b1;
            win_clears = 1'b1;
            win_rd     = md_rd;
            win_data   = md_data;
            md_ready   = 1'b1;
        end

        // x0 winners consume their handshake but never write.
        we_d    = win_valid && (win_rd != '0);
        waddr_d = win_rd;
        wdata_d = win_data;
    end

    // ------------------------------------------------------------------
    // Scoreboard next state: set has priority over clear on the same index
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign set_vec[gi] = (gi != 0) && issue_fire &&
                                 (issue_rd == REG_ADDR_BITS'(gi));
            assign clr_vec[gi] = win_clears && (win_rd == REG_ADDR_BITS'(gi));
            assign busy_d[gi]  = set_vec[gi] || (busy_q[gi] && !clr_vec[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
        end else if (sync_reset) begin
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign write_enable  = we_q;
    assign write_addr    = waddr_q;
    assign write_data_in = wdata_q;
    assign busy_vector   = busy_q;

`ifdef RV2T_WB_STATS_EN
    // ------------------------------------------------------------------
    // Conflict statistics: cycles with at least two competing candidates
    // ------------------------------------------------------------------
    logic        conflict;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    assign conflict = (alu_valid    && hold_valid_q) ||
                      (alu_valid    && ld_xfer)      ||
                      (alu_valid    && md_valid)     ||
                      (hold_valid_q && ld_xfer)      ||
                      (hold_valid_q && md_valid)     ||
                      (ld_xfer      && md_valid);

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt_q <= '0;
        end else if (sync_reset) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wb_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rv2t_reg_writeback.sv
// -----------------------------------------------------------------------------
// Testbench for rv2t_reg_writeback: directed steps in one initial block.
// Each clock step pushes the expected register-file write into a scoreboard
// queue; after the edge the entry is popped and compared with the DUT output.
// -----------------------------------------------------------------------------
module tb_rv2t_reg_writeback;

    localparam int XLEN = 32;
    localparam int RAB  = 5;
    localparam int NREG = 2**RAB;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            sync_reset;
    logic            issue_valid;
    logic [RAB-1:0]  issue_rd;
    logic            issue_ready;
    logic [RAB-1:0]  rs1_addr, rs2_addr;
    logic            rs1_busy, rs2_busy;
    logic            alu_valid;
    logic [RAB-1:0]  alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid, ld_ready;
    logic [RAB-1:0]  ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            md_valid, md_ready;
    logic [RAB-1:0]  md_rd;
    logic [XLEN-1:0] md_data;
    logic            write_enable;
    logic [RAB-1:0]  write_addr;
    logic [XLEN-1:0] write_data_in;
    logic [NREG-1:0] busy_vector;
`ifdef RV2T_WB_STATS_EN
    logic [15:0]     wb_conflict_cnt;
`endif

    always #5 clk = ~clk;

    rv2t_reg_writeback #(.XLEN(XLEN), .REG_ADDR_BITS(RAB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sync_reset    (sync_reset),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_rd         (md_rd),
        .md_data       (md_data),
`ifdef RV2T_WB_STATS_EN
        .wb_conflict_cnt (wb_conflict_cnt),
`endif
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data_in (write_data_in),
        .busy_vector   (busy_vector)
    );

    typedef struct {
        logic            we;
        logic [RAB-1:0]  addr;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  compared   = 0;
    int  mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [RAB-1:0] addr, input logic [XLEN-1:0] data);
        wr_t e;
        e.we = we; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    // One clock: sample at posedge+1 and compare against the scoreboard head.
    task automatic step(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s scoreboard empty observed_we=%0b", tag, write_enable);
        end else begin
            e = sb.pop_front();
            chk({tag, ".we"}, 64'(write_enable), 64'(e.we));
            if (e.we) begin
                chk({tag, ".addr"}, 64'(write_addr), 64'(e.addr));
                chk({tag, ".data"}, 64'(write_data_in), 64'(e.data));
            end
            $display("step %-10s we=%0b addr=%0d data=0x%08h busy=0x%08h ld_ready=%0b",
                     tag, write_enable, write_addr, write_data_in, busy_vector, ld_ready);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0;  ld_rd = 0;  ld_data = 0;
        md_valid = 0;  md_rd = 0;  md_data = 0;
    endtask

    initial begin
        idle();
        rs1_addr = 0; rs2_addr = 0;
        sync_reset = 0;
        reset_n = 0;
        #12;
        chk("rst.we",    64'(write_enable),  64'(0));
        chk("rst.addr",  64'(write_addr),    64'(0));
        chk("rst.data",  64'(write_data_in), 64'(0));
        chk("rst.busy",  64'(busy_vector),   64'(0));
        chk("rst.ldrdy", 64'(ld_ready),      64'(1));
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        push(1, 5, 32'h1234);
        step("alu");
        idle();
        chk("alu.busy", 64'(busy_vector), 64'(0));

        // Issue rd7, then complete with a load
        issue_valid = 1; issue_rd = 7;
        #1 chk("iss7.ready", 64'(issue_ready), 64'(1));
        push(0, 0, 0);
        step("iss7");
        idle();
        chk("iss7.busy", 64'(busy_vector), 64'(32'h80));
        rs1_addr = 7; rs2_addr = 0;
        #1;
        chk("iss7.rs1b", 64'(rs1_busy), 64'(1));
        chk("iss7.rs2b", 64'(rs2_busy), 64'(0));
        ld_valid = 1; ld_rd = 7; ld_data = 32'hA5A5A5A5;
        #1 chk("ld7.ready", 64'(ld_ready), 64'(1));
        push(1, 7, 32'hA5A5A5A5);
        step("ld7");
        idle();
        chk("ld7.busy", 64'(busy_vector), 64'(0));
        #1 chk("ld7.rs1b", 64'(rs1_busy), 64'(0));

        // Collision: ALU rd3 and load rd4, then md rd6 while the hold drains
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        ld_valid = 1;  ld_rd = 4;  ld_data = 32'h44;
        push(1, 3, 32'h33);
        step("col.alu");
        idle();
        md_valid = 1; md_rd = 6; md_data = 32'h66;
        #1;
        chk("col.ldrdy1", 64'(ld_ready), 64'(0));
        chk("col.mdrdy1", 64'(md_ready), 64'(0));
        push(1, 4, 32'h44);
        step("col.ld");
        #1;
        chk("col.ldrdy2", 64'(ld_ready), 64'(1));
        chk("col.mdrdy2", 64'(md_ready), 64'(1));
        push(1, 6, 32'h66);
        step("col.md");
        idle();

        // x0 write suppressed
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
        push(0, 0, 0);
        step("x0");
        idle();

        // WAW stall on rd9
        issue_valid = 1; issue_rd = 9;
        push(0, 0, 0);
        step("iss9");
        chk("iss9.busy", 64'(busy_vector), 64'(32'h200));
        #1 chk("waw.ready", 64'(issue_ready), 64'(0));
        push(0, 0, 0);
        step("waw");
        idle();
        chk("waw.busy", 64'(busy_vector), 64'(32'h200));

        // md clears rd9; then md rd9 and issue rd9 in one cycle: set wins
        md_valid = 1; md_rd = 9; md_data = 32'h99;
        push(1, 9, 32'h99);
        step("md9");
        chk("md9.busy", 64'(busy_vector), 64'(0));
        md_data = 32'h9A;
        issue_valid = 1; issue_rd = 9;
        #1;
        chk("sc.issrdy", 64'(issue_ready), 64'(1));
        chk("sc.mdrdy",  64'(md_ready),    64'(1));
        push(1, 9, 32'h9A);
        step("setclr");
        idle();
        chk("sc.busy", 64'(busy_vector), 64'(32'h200));

        // Prepare busy=0x80 with a parked load, then sync_reset
        ld_valid = 1; ld_rd = 9; ld_data = 32'h1;
        issue_valid = 1; issue_rd = 7;
        push(1, 9, 32'h1);
        step("prep.ld");
        idle();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        ld_valid = 1;  ld_rd = 2;  ld_data = 32'h22;
        push(1, 1, 32'h11);
        step("prep.alu");
        idle();
        chk("prep.busy",  64'(busy_vector), 64'(32'h80));
        chk("prep.ldrdy", 64'(ld_ready),    64'(0));
        sync_reset = 1;
        alu_valid = 1; alu_rd = 5; alu_data = 32'h55;
        push(0, 0, 0);
        step("srst");
        sync_reset = 0;
        idle();
        chk("srst.busy",  64'(busy_vector), 64'(0));
        chk("srst.ldrdy", 64'(ld_ready),    64'(1));
        push(0, 0, 0);
        step("srst.post");

        // Same setup, then async reset between edges
        issue_valid = 1; issue_rd = 7;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        ld_valid = 1;  ld_rd = 2;  ld_data = 32'h22;
        push(1, 1, 32'h11);
        step("prep2");
        idle();
        chk("prep2.busy",  64'(busy_vector), 64'(32'h80));
        chk("prep2.ldrdy", 64'(ld_ready),    64'(0));
        #2 reset_n = 0;
        #1;
        chk("arst.we",    64'(write_enable),  64'(0));
        chk("arst.addr",  64'(write_addr),    64'(0));
        chk("arst.data",  64'(write_data_in), 64'(0));
        chk("arst.busy",  64'(busy_vector),   64'(0));
        chk("arst.ldrdy", 64'(ld_ready),      64'(1));
        @(negedge clk) reset_n = 1;
        push(0, 0, 0);
        step("arst.post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
